lane_hit_judge: RTL

//  Player-input end of one falling-note lane. The lane renderer draws a note whose bottom edge
//  (note_y) advances once per frame and respawns at the top. This block samples that position

---
 rtl/lane_hit_judge.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/lane_hit_judge.sv
// Judges player presses against one falling-note lane: synchronise/debounce the button,
// latch the note row once per frame, and emit hit/perfect/miss pulses plus score and combo.
// Optional build macro: JUDGE_PERFECT_EN enables the perfect sub-window (+2 score).
module lane_hit_judge #(
    parameter logic [9:0]  HIT_Y_LO     = 10'd420,
    parameter logic [9:0]  HIT_Y_HI     = 10'd470,
    parameter logic [9:0]  PERF_Y_LO    = 10'd440,
    parameter logic [9:0]  PERF_Y_HI    = 10'd455,
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic [9:0]  note_y,
    input  logic        note_active,
    input  logic        button,
    output logic        hit_pulse,
    output logic        perfect_pulse,
    output logic        miss_pulse,
    output logic        consume,
    output logic [15:0] score,
    output logic [7:0]  combo
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DB_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_JUDGED = 2'd2
    } state_e;

    state_e           state_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_prev_q;
    logic             press_q;
    logic [CNT_W-1:0] db_cnt_q;
    logic [9:0]       y_lat_q;
    logic             hit_pulse_q;
    logic             perfect_pulse_q;
    logic             miss_pulse_q;
    logic             consume_q;
    logic [15:0]      score_q;
    logic [7:0]       combo_q;

    logic             in_win_s;
    logic             above_hi_s;
    logic             perf_win_s;
    logic             respawn_s;
    logic [15:0]      score_d;
    logic [7:0]       combo_d;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {15'd0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] a);
        return (a == 8'hFF) ? 8'hFF : (a + 8'd1);
    endfunction

`ifdef JUDGE_PERFECT_EN
    assign perf_win_s = (y_lat_q >= PERF_Y_LO) && (y_lat_q <= PERF_Y_HI);
`else
    // Perfect window compiled out; the bounds stay referenced so both builds elaborate alike.
    assign perf_win_s = 1'b0 && (PERF_Y_LO <= PERF_Y_HI);
`endif

    // Window decode on the latched row and saturated next score/combo for a hit.
    always_comb begin
        in_win_s   = (y_lat_q >= HIT_Y_LO) && (y_lat_q <= HIT_Y_HI);
        above_hi_s = (y_lat_q > HIT_Y_HI);
        respawn_s  = frame_tick && (note_y < y_lat_q);
        if (perf_win_s) begin
            score_d = sat_add16(score_q, 2'd2);
        end else begin
            score_d = sat_add16(score_q, 2'd1);
        end
        combo_d = sat_inc8(combo_q);
    end

    // Button path: two-flop synchroniser, stability counter, registered rising-edge press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            press_q       <= 1'b0;
            db_cnt_q      <= '0;
        end else begin
            sync1_q       <= button;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            press_q       <= stable_q & ~stable_prev_q;
            if (sync2_q == stable_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                stable_q <= sync2_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_ONE;
            end
        end
    end

    // Judge FSM with registered pulses, consume flag and saturating counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            y_lat_q         <= 10'd0;
            hit_pulse_q     <= 1'b0;
            perfect_pulse_q <= 1'b0;
            miss_pulse_q    <= 1'b0;
            consume_q       <= 1'b0;
            score_q         <= 16'd0;
            combo_q         <= 8'd0;
        end else begin
            hit_pulse_q     <= 1'b0;
            perfect_pulse_q <= 1'b0;
            miss_pulse_q    <= 1'b0;
            if (frame_tick) begin
                y_lat_q <= note_y;
            end
            // A row moving upwards means the lane respawned: a fresh note beats everything else.
            if (respawn_s) begin
                state_q   <= ST_IDLE;
                consume_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (note_active && in_win_s) begin
                            state_q <= ST_ARMED;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_ARMED: begin
                        // Press is weighed against the pre-tick row, so a press on the exit tick scores.
                        if (press_q && !above_hi_s) begin
                            state_q         <= ST_JUDGED;
                            hit_pulse_q     <= 1'b1;
                            perfect_pulse_q <= perf_win_s;
                            score_q         <= score_d;
                            combo_q         <= combo_d;
                            consume_q       <= 1'b1;
                        end else if (above_hi_s) begin
                            state_q      <= ST_JUDGED;
                            miss_pulse_q <= 1'b1;
                            combo_q      <= 8'd0;
                            consume_q    <= 1'b1;
                        end else if (!note_active) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_ARMED;
                        end
                    end
                    ST_JUDGED: begin
                        if (!note_active) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_JUDGED;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign hit_pulse     = hit_pulse_q;
    assign perfect_pulse = perfect_pulse_q;
    assign miss_pulse    = miss_pulse_q;
    assign consume       = consume_q;
    assign score         = score_q;
    assign combo         = combo_q;

endmodule
